// File: rtl/des_sbox_feed.sv
// des_sbox_feed: iterative DES key schedule + E-expansion feeding S1..S8; DES_KEY_PARITY_CHECK_EN adds key_err
module des_sbox_feed #(
  parameter bit PIPE_THRU = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [1:64] key,
  input  logic        start,
  input  logic        decrypt,
  output logic        busy,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [1:32] r_in,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [1:48] s_out,
  output logic [4:0]  round_idx,
  output logic        last,
  output logic        done
`ifdef DES_KEY_PARITY_CHECK_EN
  ,
  output logic        key_err
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PC1 [56] = '{57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
                              10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
                              63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
                              14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2 [48] = '{14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
                              23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
                              41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
                              44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int ETAB [48] = '{32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
                               8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
                               16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
                               24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  state_t      state, state_nx;
  logic [1:64] key_r, key_src;
  logic [1:56] pc1_v, cd_nx;
  logic [1:28] c, d, c_nx, d_nx;
  logic [1:48] k_cur, e_r;
  logic [4:0]  cnt, n;
  logic [1:0]  amt;
  logic [7:0]  odd;
  logic        dec, acc, fin, start_ok;
  function automatic logic [1:28] rot(input logic [1:28] x, input logic rr, input logic [1:0] a);
    return a == 2'd0 ? x :
           rr ? (a == 2'd1 ? {x[28], x[1:27]} : {x[27:28], x[1:26]}) :
                (a == 2'd1 ? {x[2:28], x[1]} : {x[3:28], x[1:2]});
  endfunction
  assign key_src = key_valid ? key : key_r;
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_v[i+1] = key_src[PC1[i]];
  end
  for (genvar i = 0; i < 48; i++) begin : g_pc2_e
    assign k_cur[i+1] = cd_nx[PC2[i]];
    assign e_r[i+1]   = r_in[ETAB[i]];
  end
  for (genvar i = 0; i < 8; i++) begin : g_par
    assign odd[i] = ^key_src[8*i+1 +: 8];
  end
  // decrypt walks the encrypt shift table backwards, with no shift before its first round
  always_comb begin
    n   = dec ? 5'd18 - cnt : cnt;
    amt = (dec && cnt == 5'd1) ? 2'd0 :
          (n == 5'd1 || n == 5'd2 || n == 5'd9 || n == 5'd16) ? 2'd1 : 2'd2;
  end
  assign c_nx    = rot(c, dec, amt);
  assign d_nx    = rot(d, dec, amt);
  assign cd_nx   = {c_nx, d_nx};
  assign busy    = state == RUN;
  assign r_ready = state == RUN && cnt <= 5'd16 && (!s_valid || (PIPE_THRU && s_ready));
  assign acc     = r_valid && r_ready;
  assign last    = s_valid && round_idx == 5'd16;
  assign fin     = state == RUN && s_valid && s_ready && round_idx == 5'd16;
`ifdef DES_KEY_PARITY_CHECK_EN
  assign start_ok = !(key_valid ? ~&odd : key_err);
  always_ff @(posedge clk)
    if (rst) key_err <= 1'b0;
    else if (state == IDLE && key_valid) key_err <= ~&odd;
`else
  logic parity_unused;
  assign start_ok      = 1'b1;
  assign parity_unused = ^odd;
`endif
  always_comb begin
    state_nx = state;
    if (state == IDLE && start && start_ok) state_nx = RUN;
    if (fin) state_nx = IDLE;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_ff @(posedge clk) begin
    if (rst) begin
      key_r     <= '0;
      c         <= '0;
      d         <= '0;
      dec       <= 1'b0;
      cnt       <= '0;
      s_out     <= '0;
      s_valid   <= 1'b0;
      round_idx <= '0;
      done      <= 1'b0;
    end else begin
      done <= fin;
      if (state == IDLE && key_valid) key_r <= key;
      if (state == IDLE && start && start_ok) begin
        c   <= pc1_v[1:28];
        d   <= pc1_v[29:56];
        dec <= decrypt;
        cnt <= 5'd1;
      end
      if (acc) begin
        c         <= c_nx;
        d         <= d_nx;
        cnt       <= cnt + 5'd1;
        s_out     <= e_r ^ k_cur;
        s_valid   <= 1'b1;
        round_idx <= cnt;
      end else if (s_ready) s_valid <= 1'b0;
    end
  end
endmodule

// File: doc/des_sbox_feed.md
Name: des_sbox_feed

Overview:
- Iterative DES round front-end that feeds the eight S-box lookups.
- Holds a 64-bit key and runs the DES key schedule one round at a time (PC-1, C/D rotations, PC-2).
- For each round, accepts the current 32-bit R half from the round engine and emits the 48-bit S-box input bus E(R) XOR K_i, registered.
- Sits between the round datapath register (upstream) and the S1..S8 bank (downstream). Both sides use valid/ready handshakes.

Parameters:
- PIPE_THRU, default 1: 1 gives r_ready = !s_valid || s_ready (back-to-back rounds); 0 gives r_ready = !s_valid only.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  load key (honoured only in IDLE)
- key  in  [1:64]  DES key, bit 1 = MSB, FIPS 46-3 numbering
- start  in  1  begin a 16-round sequence (honoured only in IDLE)
- decrypt  in  1  sampled with start; 1 = subkeys in order K16..K1
- busy  out  1  high in RUN
- r_valid  in  1  R half valid
- r_ready  out  1  R half accepted when r_valid && r_ready
- r_in  in  [1:32]  R half of the current round
- s_valid  out  1  s_out valid
- s_ready  in  1  downstream accepts
- s_out  out  [1:48]  E(r_in) XOR K_i; bits [1:6] go to S1 … [43:48] go to S8
- round_idx  out  [4:0]  round of the current s_out, 1..16
- last  out  1  s_valid && round_idx==16
- done  out  1  one-cycle pulse after round 16 output is accepted

Behaviour:
- Reset values:
  - s_valid=0, busy=0, done=0, last=0, r_ready=0, round_idx=0, s_out=0.
  - Key register, C, D cleared to 0; state IDLE.
- IDLE state:
  - key_valid loads the 64-bit key register.
  - On start: C/D = PC-1(key register), mode latched, round counter = 1, go to RUN.
  - If key_valid and start are high in the same cycle, the new key is loaded and used for the run.
  - r_ready=0 in IDLE.
- Subkey generation:
  - Encrypt: before round i, rotate C and D left by 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for i=1..16; K_i = PC-2(C,D).
  - Decrypt: round 1 uses unrotated C0/D0, so K16 = PC-2(C0,D0). Before rounds 2..16, rotate C and D right by 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - Rotation happens combinationally on the R handshake; the rotated C/D is registered.
- RUN state:
  - On r_valid && r_ready: s_out <= E(r_in) XOR K_current, s_valid <= 1, round_idx <= counter. Latency is 1 cycle from accept to s_valid.
  - s_out is held stable while s_valid && !s_ready.
  - The output register clears s_valid on s_ready unless a new accept occurs in the same cycle (PIPE_THRU=1).
  - Counter increments on each accept.
  - After the 16th accept, r_ready=0.
  - When round 16 is accepted downstream: done=1 for one cycle, busy=0, back to IDLE.
- Ignored inputs:
  - start and key_valid are ignored while busy.
  - r_valid is ignored in IDLE.
- Expansion E and PC-1/PC-2 are the standard FIPS 46-3 tables, purely combinational. E is 32→48 bits and duplicates edge bits.
- rst at any cycle aborts the run:
  - next cycle all outputs take their reset values, the key is cleared, and no done pulse is produced.

Optional Feature:
- Macro: DES_KEY_PARITY_CHECK_EN
- Compiled in:
  - Adds output key_err (1 bit, reset 0).
  - On key load, key_err <= 1 if any key byte has even parity (bits 8,16,…,64 are parity bits; odd parity is required); otherwise 0.
  - start is ignored while key_err=1: stays IDLE, busy stays 0.
- Compiled out:
  - No key_err port; parity bits are ignored; start always honoured in IDLE.

Test Plan:
1. key=133457799BBCDFF1, start with decrypt=0, r_in=F0AAF0AA, s_ready=1 → one cycle after accept: s_valid=1, round_idx=1, s_out=6117BA866527 (K1=1B02EFFC7072).
2. Same key, decrypt=1, r_in=00000000 → first s_out=CB3D8B0E17F5 (K16), round_idx=1.
3. Encrypt run, 16 rounds with r_in=00000000 and s_ready held 1 → s_out sequence equals K1..K16; last asserted on round 16; done pulses once; busy drops; r_ready=0 after the 16th accept.
4. Backpressure:
   - s_ready=0 for 5 cycles mid-run → s_out and round_idx held stable, r_ready=0 (PIPE_THRU=1).
   - On release, the next round continues with no lost or duplicated round.
5. rst asserted at round 7 → next cycle s_valid=0, busy=0, round_idx=0, IDLE; a subsequent start without a key reload runs with key 0 (K1=000000000000).
6. With DES_KEY_PARITY_CHECK_EN: load key 133457799BBCDFF0 → key_err=1, start ignored; reload 133457799BBCDFF1 → key_err=0, run proceeds as in scenario 1.
